// File: rtl/seg7_sched_pkg.sv
// seg7_sched_pkg: shared FSM state type and constants for the seven-segment display scheduler.
package seg7_sched_pkg;
  typedef enum logic [1:0] {IDLE, ADVANCE, SHOW} state_e;
  localparam logic MODE_ROTATE = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  localparam int DIGITS = 4;
endpackage

// File: rtl/seg7_tick_gen.sv
// seg7_tick_gen: divider emitting a 1-cycle pulse every DIV cycles; clr_i restarts the period.
module seg7_tick_gen #(
  parameter int DIV = 2
)(
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);
  localparam int W = $clog2(DIV + 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = !clr_i && cnt_q == W'(DIV - 1);
  assign cnt_d = clr_i || tick_o ? '0 : cnt_q + W'(1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/seg7_display_sched.sv
// seg7_display_sched: time-shares a 4-digit hex display between NUM_SRC requesters and paces the scanner.
// Define SEG7_SCHED_BLINK_EN to blink the display while frozen.
module seg7_display_sched
  import seg7_sched_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int SCAN_DIV = 100_000,
  parameter int BLINK_CYCLES = 25_000_000,
  localparam int SEL_W = $clog2(NUM_SRC)
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_SRC*16-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  freeze,
  output logic [15:0]           disp_data,
  output logic [SEL_W-1:0]      disp_src,
  output logic                  disp_blank,
  output logic                  scan_tick,
  output logic [1:0]            scan_digit
);
  localparam int DW = $clog2(DWELL_CYCLES);

  if (NUM_SRC < 2 || NUM_SRC > 8 || DWELL_CYCLES < 2 || SCAN_DIV < 2 || BLINK_CYCLES < 1) begin : g_bad_params
    $error("seg7_display_sched: parameter out of range");
  end

  // Lowest-offset valid source at or after start, wrapping; MSB flags a hit.
  function automatic logic [SEL_W:0] next_valid(input logic [NUM_SRC-1:0] v, input int start);
    logic [SEL_W:0] r;
    r = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (v[(start + k) % NUM_SRC]) r = {1'b1, SEL_W'((start + k) % NUM_SRC)};
    return r;
  endfunction

  state_e state_q, state_d;
  logic [15:0] data_q, data_d, cur_data;
  logic [SEL_W-1:0] src_q, src_d, sel_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [$clog2(DIGITS)-1:0] digit_q;
  logic [SEL_W:0] pick;
  logic blank_q, blank_d, first_q, first_d, mode_q;
  logic cur_valid, fixed_ok, changed, at_limit, expired, frz_blank;

  seg7_tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk(clk),
    .rst(rst),
    .clr_i(1'b0),
    .tick_o(scan_tick)
  );

`ifdef SEG7_SCHED_BLINK_EN
  logic frz_show, frz_show_q, blink_start, blink_tick;
  assign frz_show = freeze && state_q == SHOW;
  assign blink_start = frz_show && !frz_show_q;
  seg7_tick_gen #(.DIV(BLINK_CYCLES)) u_blink (
    .clk(clk),
    .rst(rst),
    .clr_i(!frz_show || blink_start),
    .tick_o(blink_tick)
  );
  always_ff @(posedge clk) frz_show_q <= rst ? 1'b0 : frz_show;
  assign frz_blank = blink_start ? 1'b1 : blink_tick ? !blank_q : blank_q;
`else
  assign frz_blank = 1'b0;
`endif

  assign cur_valid = src_valid[src_q];
  assign cur_data = src_data[16*src_q +: 16];
  assign fixed_ok = int'(sel) < NUM_SRC && src_valid[sel];
  assign pick = mode == MODE_FIXED ? {fixed_ok, sel} : next_valid(src_valid, first_q ? 0 : int'(src_q) + 1);
  assign changed = mode != mode_q || (mode == MODE_FIXED && sel != sel_q);
  assign at_limit = dwell_q == DW'(DWELL_CYCLES - 1);
  assign expired = mode == MODE_ROTATE && at_limit;

  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;

  always_comb
    state_d = state_q == IDLE ? (|src_valid ? ADVANCE : IDLE)
            : state_q == ADVANCE ? (pick[SEL_W] ? SHOW : IDLE)
            : (!cur_valid || (!freeze && (changed || expired))) ? ADVANCE : SHOW;

  always_comb begin
    data_d = data_q;
    src_d = src_q;
    blank_d = blank_q;
    dwell_d = dwell_q;
    first_d = first_q;
    if (state_q == IDLE) begin
      data_d = '0;
      blank_d = 1'b1;
    end else if (state_q == ADVANCE) begin
      data_d = pick[SEL_W] ? src_data[16*pick[SEL_W-1:0] +: 16] : '0;
      blank_d = !pick[SEL_W];
      if (pick[SEL_W]) begin
        src_d = pick[SEL_W-1:0];
        dwell_d = '0;
        first_d = 1'b0;
      end
    end else if (!freeze) begin
      data_d = cur_data;
      dwell_d = at_limit ? dwell_q : dwell_q + DW'(1);
      blank_d = 1'b0;
    end else begin
      blank_d = frz_blank;
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      data_q <= '0;
      src_q <= '0;
      blank_q <= 1'b1;
      dwell_q <= '0;
      first_q <= 1'b1;
      mode_q <= MODE_ROTATE;
      sel_q <= '0;
      digit_q <= '0;
    end else begin
      data_q <= data_d;
      src_q <= src_d;
      blank_q <= blank_d;
      dwell_q <= dwell_d;
      first_q <= first_d;
      mode_q <= mode;
      sel_q <= sel;
      digit_q <= digit_q + {1'b0, scan_tick};
    end

  assign disp_data = data_q;
  assign disp_src = src_q;
  assign disp_blank = blank_q;
  assign scan_digit = digit_q;
endmodule

// File: tb/tb_seg7_display_sched.sv
// tb_seg7_display_sched: directed, table-driven and randomized checks against a behavioural model.
module tb_seg7_display_sched;
  localparam int N = 4, DWELL = 8, SDIV = 4, BLINK = 3;
`ifdef SEG7_SCHED_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, mode = 1'b0, freeze = 1'b0;
  logic [63:0] src_data = '0;
  logic [3:0] src_valid = '0;
  logic [1:0] sel = '0;
  logic [15:0] disp_data;
  logic [1:0] disp_src, scan_digit;
  logic disp_blank, scan_tick;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  seg7_display_sched #(.NUM_SRC(N), .DWELL_CYCLES(DWELL), .SCAN_DIV(SDIV), .BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid), .mode(mode), .sel(sel),
    .freeze(freeze), .disp_data(disp_data), .disp_src(disp_src), .disp_blank(disp_blank),
    .scan_tick(scan_tick), .scan_digit(scan_digit)
  );

  // Model: phase 0 = dark/waiting, 1 = choosing, 2 = showing; m_n = cycles since reset.
  int m_phase, m_src, m_dwell, m_n, m_frz_len, m_psel;
  logic [15:0] m_data;
  logic m_blank, m_fresh, m_pmode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_src = 0; m_dwell = 0; m_n = 0; m_frz_len = 0; m_psel = 0;
    m_data = '0; m_blank = 1'b1; m_fresh = 1'b1; m_pmode = 1'b0;
  endtask

  task automatic model_step();
    int cand;
    bit found, leave;
    if (rst) begin
      model_reset();
      return;
    end
    m_n++;
    if (m_phase == 0) begin
      m_data = '0; m_blank = 1'b1; m_frz_len = 0;
      if (src_valid != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      found = 0; cand = 0; m_frz_len = 0;
      if (mode) begin
        cand = int'(sel);
        found = src_valid[cand];
      end else begin
        for (int off = 0; off < N && !found; off++) begin
          cand = m_fresh ? off : (m_src + 1 + off) % N;
          found = src_valid[cand];
        end
      end
      if (found) begin
        m_src = cand; m_data = src_data[16*cand +: 16]; m_blank = 1'b0; m_dwell = 0; m_fresh = 1'b0; m_phase = 2;
      end else begin
        m_data = '0; m_blank = 1'b1; m_phase = 0;
      end
    end else begin
      leave = !src_valid[m_src] ||
              (!freeze && (mode != m_pmode || (mode && int'(sel) != m_psel) || (!mode && m_dwell == DWELL - 1)));
      if (freeze) begin
        m_blank = BLINK_EN && (m_frz_len / BLINK) % 2 == 0;
        m_frz_len++;
      end else begin
        m_data = src_data[16*m_src +: 16];
        m_dwell = m_dwell < DWELL - 1 ? m_dwell + 1 : m_dwell;
        m_blank = 1'b0;
        m_frz_len = 0;
      end
      if (leave) m_phase = 1;
    end
    m_pmode = mode;
    m_psel = int'(sel);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("m_data", disp_data, m_data);
    chk("m_src", disp_src, m_src);
    chk("m_blank", disp_blank, m_blank);
    chk("m_tick", scan_tick, (m_n % SDIV) == SDIV - 1);
    chk("m_digit", scan_digit, (m_n / SDIV) % 4);
  endtask

  task automatic wait_unblank(input string name);
    int k;
    k = 0;
    while (disp_blank !== 1'b0 && k < 30) begin cyc(); k++; end
    chk(name, k < 30, 1);
  endtask

  task automatic count_until_src_change(output int cnt);
    logic [1:0] s;
    s = disp_src;
    cnt = 0;
    while (disp_src === s && cnt < 40) begin cyc(); cnt++; end
  endtask

  typedef struct {
    logic [3:0] valid;
    logic tick;
    logic [1:0] digit;
    logic blank;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tv[13];
    int cnt;
    tv = '{'{4'h0, 0, 0, 1}, '{4'h0, 0, 0, 1}, '{4'h0, 0, 0, 1}, '{4'h0, 1, 0, 1},
           '{4'h0, 0, 1, 1}, '{4'h0, 0, 1, 1}, '{4'h0, 0, 1, 1}, '{4'h0, 1, 1, 1},
           '{4'h0, 0, 2, 1}, '{4'h0, 0, 2, 1}, '{4'h0, 0, 2, 1}, '{4'h0, 1, 2, 1},
           '{4'h0, 0, 3, 1}};
    model_reset();
    cyc();
    cyc();
    chk("rst_data", disp_data, 0);
    chk("rst_src", disp_src, 0);
    chk("rst_blank", disp_blank, 1);
    chk("rst_tick", scan_tick, 0);
    chk("rst_digit", scan_digit, 0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      src_valid = tv[i].valid;
      chk("t1_tick", scan_tick, tv[i].tick);
      chk("t1_digit", scan_digit, tv[i].digit);
      chk("t1_blank", disp_blank, tv[i].blank);
      chk("t1_data", disp_data, 0);
      cyc();
    end

    src_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    src_valid = 4'b1011;
    wait_unblank("t2_start");
    chk("t2_src0", disp_src, 0);
    chk("t2_d0", disp_data, 16'h1111);
    count_until_src_change(cnt);
    chk("t2_len0", cnt, DWELL + 1);
    chk("t2_src1", disp_src, 1);
    chk("t2_d1", disp_data, 16'h2222);
    count_until_src_change(cnt);
    chk("t2_len1", cnt, DWELL + 1);
    chk("t2_src3", disp_src, 3);
    chk("t2_d3", disp_data, 16'h4444);
    count_until_src_change(cnt);
    chk("t2_len3", cnt, DWELL + 1);
    chk("t2_wrap", disp_src, 0);
    chk("t2_dwrap", disp_data, 16'h1111);

    mode = 1'b1; sel = 2'd2; src_valid = 4'b0100; src_data[47:32] = 16'hBEEF;
    cnt = 0;
    while (disp_src !== 2'd2 && cnt < 10) begin cyc(); cnt++; end
    chk("t3_sel", disp_src, 2);
    chk("t3_beef", disp_data, 16'hBEEF);
    src_data[47:32] = 16'hCAFE;
    chk("t3_hold", disp_data, 16'hBEEF);
    cyc();
    chk("t3_cafe", disp_data, 16'hCAFE);
    repeat (20) cyc();
    chk("t3_noexp", disp_src, 2);
    chk("t3_lit", disp_blank, 0);
    src_valid = 4'b0000;
    cyc();
    cyc();
    chk("t3_dark", disp_blank, 1);
    chk("t3_zero", disp_data, 0);

    mode = 1'b0; src_valid = 4'b0001;
    wait_unblank("t4_start");
    chk("t4_src0", disp_src, 0);
    src_valid = 4'b1011;
    repeat (5) cyc();
    freeze = 1'b1; src_data[15:0] = 16'h5A5A;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      chk("t4_src", disp_src, 0);
      chk("t4_data", disp_data, 16'h1111);
      chk("t4_blink", disp_blank, BLINK_EN && ((k - 1) / BLINK) % 2 == 0);
    end
    freeze = 1'b0; src_data[15:0] = 16'h1111;
    count_until_src_change(cnt);
    chk("t4_resume", cnt, 4);
    chk("t4_next", disp_src, 1);

    repeat (3) cyc();
    src_valid = 4'b1001;
    cyc();
    chk("t5_adv", disp_src, 1);
    cyc();
    chk("t5_src3", disp_src, 3);
    chk("t5_d3", disp_data, 16'h4444);
    src_valid = 4'b0001;
    cyc();
    cyc();
    chk("t5_src0", disp_src, 0);
    chk("t5_d0", disp_data, 16'h1111);

    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("t6_data", disp_data, 0);
    chk("t6_src", disp_src, 0);
    chk("t6_blank", disp_blank, 1);
    chk("t6_tick", scan_tick, 0);
    chk("t6_digit", scan_digit, 0);
    rst = 1'b0; src_valid = 4'b0011;
    wait_unblank("t6_start");
    chk("t6_first", disp_src, 0);

    for (int i = 0; i < 2000; i++) begin
      int j;
      rst = $urandom_range(0, 399) == 0;
      if ($urandom_range(0, 15) == 0) src_valid = 4'($urandom);
      if ($urandom_range(0, 30) == 0) mode = ~mode;
      if ($urandom_range(0, 20) == 0) sel = 2'($urandom);
      if ($urandom_range(0, 25) == 0) freeze = ~freeze;
      if ($urandom_range(0, 3) == 0) begin
        j = $urandom_range(0, 3);
        src_data[16*j +: 16] = 16'($urandom);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
